// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber Z_q arithmetic blocks.
package kyber_pkg;

    localparam int Q     = 3329;
    localparam int WIDTH = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/moddouble_step.sv
// Single modular doubling step: r2 = 2*r mod Q, for r already in 0..Q-1.
module moddouble_step
    import kyber_pkg::*;
#(
    parameter int WIDTH_P = WIDTH,
    parameter int Q_P     = Q
) (
    input  logic [WIDTH_P-1:0] r,
    output logic [WIDTH_P-1:0] r2
);

    // Compare is done on the full WIDTH+1-bit doubled value so the carry is never lost.
    localparam logic [WIDTH_P:0] QW = (WIDTH_P+1)'(Q_P);

    logic [WIDTH_P:0] t;

    // Double, then one conditional subtract brings the result back into 0..Q-1.
    always_comb begin
        t  = {r, 1'b0};
        r2 = t[WIDTH_P-1:0];
        if (t >= QW) begin
            r2 = WIDTH_P'(t - QW);
        end
    end

endmodule

// File: rtl/moddoubleq.sv
// Sequential modular doubler: b = a * 2^k mod Q, one doubling per clock.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | applying one doubling per cycle until cnt reaches zero
// DONE  | result on b, out_valid high until out_ready handshake
module moddoubleq
    import kyber_pkg::*;
#(
    parameter int WIDTH_P = WIDTH,
    parameter int Q_P     = Q,
    parameter int KW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_P-1:0] a,
    input  logic [KW-1:0]      k,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_P-1:0] b
);

    localparam logic [WIDTH_P-1:0] QN = WIDTH_P'(Q_P);

    state_t             state_q, state_d;
    logic [WIDTH_P-1:0] r_q, r_d;
    logic [KW-1:0]      cnt_q, cnt_d;

    logic [WIDTH_P-1:0] red1;
    logic [WIDTH_P-1:0] red2;
    logic [WIDTH_P-1:0] step_out;

    moddouble_step #(
        .WIDTH_P(WIDTH_P),
        .Q_P    (Q_P)
    ) u_step (
        .r (r_q),
        .r2(step_out)
    );

    // Input reduction: 2^WIDTH < 3Q, so two conditional subtracts always suffice.
    always_comb begin
        red1 = a;
        if (a >= QN) begin
            red1 = a - QN;
        end
        red2 = red1;
        if (red1 >= QN) begin
            red2 = red1 - QN;
        end
    end

    // Next-state and datapath updates for the accept / run / done sequence.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = red2;
                    cnt_d   = k;
                    state_d = (k == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                r_d   = step_out;
                cnt_d = cnt_q - KW'(1);
                if (cnt_q == KW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign b         = r_q;

endmodule

// File: tb/tb_moddoubleq.sv
// Scoreboard bench for moddoubleq with a behavioural Z_q reference model.
module tb_moddoubleq;

    localparam int QM = 3329;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] a = '0;
    logic [3:0]  k = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [12:0] b;

    typedef struct {
        int exp_b;
        int kk;
        int acc_cyc;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    rand_or = 1'b0;

    moddoubleq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .k        (k),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .b        (b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rand_or) out_ready = 1'($urandom_range(0, 1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: (a mod q) * 2^k mod q, plain arithmetic.
    function automatic int ref_double(input int av, input int kv);
        longint p;
        p = (longint'(av % QM)) * (longint'(1) << kv);
        return int'(p % QM);
    endfunction

    // Behavioural halving unit: h with 2h == r (mod q).
    function automatic int ref_half(input int av);
        int r;
        r = av % QM;
        return (r % 2 == 0) ? r / 2 : (r + QM) / 2;
    endfunction

    // Monitor: pop on each new result, check value, latency and hold stability.
    int  cur_exp = 0;
    bit  prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst && out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                item_t it;
                it = sb.pop_front();
                cur_exp = it.exp_b;
                chk("result_b", int'(b), it.exp_b);
                chk("latency_k_plus_1", cyc - it.acc_cyc + 1, it.kk + 1);
            end
        end else if (!rst && out_valid) begin
            chk("b_stable_in_done", int'(b), cur_exp);
        end
        prev_ov = out_valid;
    end

    task automatic send_exp(input int av, input int kv, input int expb);
        int n;
        n = 0;
        @(negedge clk);
        a = 13'(av);
        k = 4'(kv);
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            sb.push_back('{expb, kv, cyc + 1});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input int av, input int kv);
        send_exp(av, kv, ref_double(av, kv));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !in_ready) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        // Reset held with random in_valid: outputs fixed, nothing accepted.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("rst_in_ready", int'(in_ready), 1);
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_b", int'(b), 0);
            end
            in_valid = 1'($urandom_range(0, 1));
            a = 13'($urandom_range(0, 8191));
            k = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", int'(in_ready), 1);

        send(5, 1);
        drain();
        chk("b_eq_10_held", int'(b), 10);

        // Reduction and wrap.
        send(1700, 1);
        send(3328, 1);
        send(8191, 0);
        drain();
        chk("b_8191_k0", int'(b), 1533);

        // Long shifts.
        send(1, 12);
        send(1, 15);
        drain();
        chk("b_1_k15", int'(b), 2807);

        // Backpressure.
        out_ready = 1'b0;
        send(100, 2);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        in_valid = 1'b1;
        a = 13'd7;
        k = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_b", int'(b), 400);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_after_hs", int'(in_ready), 1);
        send(7, 0);
        drain();

        // Mid-operation reset.
        send(1, 15);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_b", int'(b), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        send(2, 3);
        drain();
        chk("after_mid_rst_b", int'(b), 16);

        // Random operands with random backpressure.
        rand_or = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(int'($urandom_range(0, 8191)), int'($urandom_range(0, 15)));
        end
        drain();
        rand_or = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Inverse of the halving unit: double(half(a)) == a mod q.
        for (int i = 0; i < 1000; i++) begin
            int av;
            av = int'($urandom_range(0, 8191));
            send_exp(ref_half(av), 1, av % QM);
        end
        drain();
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/moddoubleq.md
# moddoubleq

Sequential modular doubler over the Kyber prime field Z_q (q = 3329): returns b = a·2^k mod q, one doubling per clock, with a valid/ready handshake on both sides. It is the inverse of the existing halving unit `modhalfq`: `modhalfq` followed by `moddoubleq` with k = 1 returns a mod q. It sits in the NTT/arithmetic datapath wherever a value scaled by 2^-k must be rescaled, for example to undo halving-based normalisation.

## Interface
- WIDTH, 13, coefficient width; must satisfy 2^WIDTH < 3·Q.
- Q, 3329, modulus.
- KW, 4, width of the shift count k (0..15).

- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  a and k are valid.
- in_ready  output  1  block can accept an operand.
- a  input  WIDTH  operand, any value 0..2^WIDTH-1, not necessarily reduced.
- k  input  KW  number of doublings.
- out_valid  output  1  b is valid.
- out_ready  input  1  consumer accepts b.
- b  output  WIDTH  result, always in 0..Q-1 when out_valid is high.

## Operation
- FSM with three states:
  - IDLE: in_ready = 1.
  - RUN: in_ready = 0, out_valid = 0.
  - DONE: out_valid = 1, in_ready = 0.
- **Accept.** Acceptance happens on a rising edge where in_valid && in_ready.
  - r <= a reduced to 0..Q-1 in the same cycle, using two cascaded conditional subtracts of Q.
  - cnt <= k.
  - Next state is DONE if k == 0, otherwise RUN.
- **RUN.** Each edge does t = {r,1'b0} (WIDTH+1 bits); r <= (t >= Q) ? t - Q : t; cnt <= cnt - 1.
  - The edge on which cnt == 1 moves the FSM to DONE.
- **DONE.** b = r. On an edge with out_ready high, go to IDLE.
  - b stays stable until that handshake edge.
- No overlap: a new operand is accepted only in IDLE, so at most one operation is in flight.
- **Reset.** rst high on any edge does the following, regardless of state, including mid-RUN and in DONE without a handshake:
  - state <= IDLE, r <= 0, cnt <= 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, b = 0.
  - An in-flight result is discarded.
- b is a registered output, equal to r, and holds its last value while in IDLE.
- Width rule: the doubling intermediate is WIDTH+1 bits. The reduction compare uses the full WIDTH+1 bits, so there is no truncation before the compare.

## Timing
- Acceptance is at edge E0. out_valid is first high in the cycle after edge E0+k, giving latency k+1 cycles (k = 0 gives 1 cycle).
- in_ready drops in the cycle after E0.
- Leaving DONE:
  - If out_ready is high in the first DONE cycle, the DONE→IDLE edge is E0+k+1, and in_ready is high again in the following cycle.
  - Throughput is one result per k+2 cycles with no backpressure.
- in_valid during RUN or DONE is ignored. The upstream must hold a/k until in_ready is seen high.
- out_ready during IDLE or RUN has no effect.
- A simultaneous in_valid and rst: reset wins and nothing is accepted.

## Structure
- Shared package `kyber_pkg`:
  - constants Q = 3329 and WIDTH = 13;
  - a state enum {IDLE, RUN, DONE}.
- One natural sub-module, `moddouble_step`: combinational, takes r in WIDTH bits and returns (2r mod Q) in WIDTH bits.
  - It is instantiated once and feeds the r register during RUN.
  - It is reused by other arithmetic blocks.
- The input reduction (two conditional subtracts) lives inline in `moddoubleq`.

## Test plan
- **Reset.** rst high for 25 cycles with random in_valid.
  - Expect in_ready = 1, out_valid = 0, b = 0 throughout; nothing is accepted.
  - Then apply a = 5, k = 1 → b = 10, with out_valid first high 2 cycles after acceptance.
- **Reduction and wrap.**
  - a = 1700, k = 1 → b = 71.
  - a = 3328, k = 1 → b = 3327.
  - a = 8191, k = 0 → b = 1533, with latency 1.
- **Long shifts.**
  - a = 1, k = 12 → b = 767.
  - a = 1, k = 15 → b = 2807, with out_valid first high 16 cycles after acceptance.
- **Backpressure.** a = 100, k = 2 with out_ready low for 10 cycles.
  - b = 400 and out_valid stay stable; in_ready stays 0 and a new in_valid is not accepted.
  - After out_ready rises for one cycle: IDLE, then the next operand is accepted.
- **Mid-operation reset.** a = 1, k = 15; rst is pulsed for 1 cycle at the 5th RUN cycle.
  - Expect out_valid = 0, b = 0 and in_ready = 1 after the reset edge.
  - The next operation a = 2, k = 3 → b = 16 is correct.
- **Inverse check against `modhalfq`.** 1000 random 13-bit a values are fed through `modhalfq`; each output goes into `moddoubleq` with k = 1.
  - Expect b == a mod 3329 every time; any mismatch sets the fail flag and is reported.
